fp_multi_pipe_unit: RTL and testbench
=====================================

// Module: fp_multi_pipe_unit
// PURPOSE
// Generic FP long-latency execution unit: one issue port fans into NUM_PIPES fixed-latency, clock-enabled
// arithmetic cores (e.g. div, sqrt, and later fused ops). Each core is external and driven via core_* ports.
// Per-pipe valid/id shadow pipelines track in-flight ops. A round-robin arbiter merges core tails into one
// registered writeback. Generalises the two-pipe div/sqrt unit: N pipes, per-pipe latency, fair arbitration.
// PARAMETERS
// NUM_PIPES    2          number of attached cores (>=1)
// PIPE_LATENCY '{10,8}    int array[NUM_PIPES]; core latency in ce-enabled cycles, excluding unit in/out regs (>=1)
// DATA_W       34         operand/result width (flopoco format incl. 2 exception bits)
// SEL_W        $clog2(NUM_PIPES) (min 1)  pipe-select width
// PORTS
// clk                  in   1                 clock
// rst                  in   1                 synchronous active-high reset
// op_sel               in   SEL_W             target pipe of new request
// rs1, rs2             in   DATA_W            operands
// issue.new_request    in   1                 issue valid
// issue.id             in   id_t              instruction id
// issue.ready          out  1                 unit can accept this cycle
// core_a, core_b       out  DATA_W            registered operands, shared by all cores
// core_ce              out  NUM_PIPES         per-core clock enable
// core_r               in   NUM_PIPES*DATA_W  core results, pipe p at [p*DATA_W +: DATA_W]
// wb.ack               in   1                 writeback accepted
// wb.done              out  1                 result valid
// wb.id                out  id_t              result id
// wb.rd                out  DATA_W            result
// flush (FP_PIPE_FLUSH_EN only)  in  1        discard all in-flight ops
// BEHAVIOUR
// - Input stage: valid_in, sel_r, id_r, and core_a/core_b load when adv_in.
//   adv_in = !valid_in || adv_pipe[sel_r]. Uses the REGISTERED select, not op_sel.
//   issue.ready = adv_in. valid_in <= issue.new_request on adv_in.
// - op_sel >= NUM_PIPES is illegal and must be assertion-checked in simulation.
// - Pipe p: valid_p[0..L-1] and id_p[0..L-1], L = PIPE_LATENCY[p]. On adv_pipe[p]:
//   valid_p[0] <= valid_in && sel_r==p; id_p[0] <= id_r; all entries shift by one.
//   core_ce[p] = adv_pipe[p] = !valid_p[L-1] || (grant[p] && adv_out).
//   A stalled pipe freezes entirely; no bubble collapse.
// - Arbiter: candidates are the pipes with valid_p[L-1] set. Round-robin from pointer rr
//   (reset 0); grant is one-hot.
//   rr <= winner+1 (mod NUM_PIPES) only when adv_out && any candidate.
// - Output register: adv_out = !done_r || wb.ack.
//   On adv_out: done_r <= |candidates; rd <= core_r[winner]; id <= id_winner[L-1].
// - Latency, no stall: request accepted in cycle t gives wb.done=1 in cycle t+L+2.
//   Throughput is 1 op/cycle across pipes.
// - Back-to-back ops into different pipes are allowed. Ops retire out of order (by id).
// - Simultaneous tails: exactly one is granted per adv_out. Losers hold their tail and stall their pipe.
// - wb.ack while done_r=0 is ignored. Output holds stable while done_r && !wb.ack.
// - Reset, including mid-operation: all valid bits, done_r and rr clear. Data/id regs are not reset.
//   Post-reset values: wb.done=0, issue.ready=1, core_ce=all ones.
//   In-flight ops are lost and their core contents are discarded.
// CONFIGURATION
// FP_PIPE_FLUSH_EN defined:
// - Adds the flush port.
// - flush=1 clears valid_in, every valid_p[*] and done_r at the next edge. Data regs, core state and rr are kept.
// - A request presented in a flush cycle is dropped. issue.ready is unchanged by flush.
// - flush and rst together behave as rst.
// FP_PIPE_FLUSH_EN undefined: no flush port. Valid state is cleared only by rst.
// TESTING
// 1 Single op to pipe0 (L=10), wb.ack tied 1, at t=0 -> wb.done=1 exactly at t=12 with the correct id, one cycle wide.
// 2 Alternate ops to pipe0/pipe1 every cycle for 20 cycles, ack=1 -> issue.ready stays 1.
//   All 20 ids retire exactly once, and pipe1 ops overtake earlier pipe0 ops.
// 3 Arrange pipe0 and pipe1 tails valid in the same cycle, rr=0 -> pipe0 result first, pipe1 next cycle.
//   Repeat with rr=1 -> pipe1 first.
// 4 wb.ack=0 for 30 cycles under continuous issue to pipe1 -> pipe1 fills (8 in pipe, 1 in input, 1 in output).
//   issue.ready drops. No id is lost or duplicated after ack=1.
// 5 Assert rst while 5 ops are in flight -> next cycle wb.done=0 and issue.ready=1.
//   No stale result appears within 20 cycles.
// 6 (FP_PIPE_FLUSH_EN) Assert flush with 4 ops in flight and a new request in the same cycle -> no wb.done for all 4 or the new one.
//   A request issued the cycle after completes normally.

Source files
------------

// File: rtl/fp_multi_pipe_unit.sv
// fp_multi_pipe_unit
// A long-latency FP execution unit. A single issue port feeds NUM_PIPES external
// fixed-latency cores, which are clock-enabled through core_ce. Each pipe has a
// valid/id shadow pipeline that tracks the ops in flight. A round-robin arbiter
// merges the pipe tails into one registered writeback port.
//
// Optional feature: define FP_PIPE_FLUSH_EN to add the flush input. Flush
// discards every in-flight op at the next edge.
//
// Handshakes (strict valid/ready on both ports):
//   issue: a request transfers on a rising edge where issue_new_request && issue_ready.
//          issue_ready never depends on issue_new_request in the same cycle.
//   wb:    a result transfers on a rising edge where wb_done && wb_ack. While
//          wb_done && !wb_ack, wb_id and wb_rd hold stable. wb_ack is ignored
//          while wb_done is low.
module fp_multi_pipe_unit #(
    parameter int NUM_PIPES                = 2,
    parameter int PIPE_LATENCY [NUM_PIPES] = '{10, 8},
    parameter int DATA_W                   = 34,
    parameter int ID_W                     = 8,
    parameter int SEL_W                    = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef FP_PIPE_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic [SEL_W-1:0]              op_sel,
    input  logic [DATA_W-1:0]             rs1,
    input  logic [DATA_W-1:0]             rs2,
    input  logic                          issue_new_request,
    input  logic [ID_W-1:0]               issue_id,
    output logic                          issue_ready,
    output logic [DATA_W-1:0]             core_a,
    output logic [DATA_W-1:0]             core_b,
    output logic [NUM_PIPES-1:0]          core_ce,
    input  logic [NUM_PIPES*DATA_W-1:0]   core_r,
    input  logic                          wb_ack,
    output logic                          wb_done,
    output logic [ID_W-1:0]               wb_id,
    output logic [DATA_W-1:0]             wb_rd
);

    // ------------------------------------------------------------------
    // Flush qualifier. It is tied low when the feature is not built, so the
    // valid-clearing logic below is the same in both builds.
    // ------------------------------------------------------------------
    logic flush_now;
`ifdef FP_PIPE_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Shared declarations
    // ------------------------------------------------------------------
    logic                 valid_in;
    logic [SEL_W-1:0]     sel_r;
    logic [ID_W-1:0]      id_r;
    logic                 adv_in;
    logic                 sel_adv;

    logic [NUM_PIPES-1:0] adv_pipe;
    logic [NUM_PIPES-1:0] tail_valid;
    logic [ID_W-1:0]      tail_id  [NUM_PIPES];
    logic [DATA_W-1:0]    core_res [NUM_PIPES];

    logic [NUM_PIPES-1:0] grant;
    logic [SEL_W-1:0]     winner;
    logic                 any_tail;
    logic [SEL_W-1:0]     rr;

    logic                 done_r;
    logic                 adv_out;

    // ------------------------------------------------------------------
    // Input stage
    // The input register advances when it is empty, or when the pipe it
    // targets can take its content. The registered select is used here, so
    // a stalled pipe blocks only the op that is waiting for it.
    // ------------------------------------------------------------------

    // Pick the advance of the pipe that the held op targets.
    always_comb begin
        sel_adv = 1'b0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            if (sel_r == SEL_W'(p)) begin
                sel_adv = adv_pipe[p];
            end
        end
    end

    assign adv_in      = !valid_in || sel_adv;
    assign issue_ready = adv_in;

    // Valid bit of the input stage. Cleared by reset or flush, so a request
    // presented together with a flush is dropped.
    always_ff @(posedge clk) begin
        if (rst || flush_now) begin
            valid_in <= 1'b0;
        end else if (adv_in) begin
            valid_in <= issue_new_request;
        end
    end

    // Operand, select and id registers of the input stage. These have no reset.
    always_ff @(posedge clk) begin
        if (adv_in) begin
            sel_r  <= op_sel;
            id_r   <= issue_id;
            core_a <= rs1;
            core_b <= rs2;
        end
    end

    // ------------------------------------------------------------------
    // Per-pipe shadow pipelines
    // Each shadow pipeline shifts in lock-step with its core, which is
    // enabled by the same adv_pipe bit. vld[L-1] and ids[L-1] therefore line
    // up with the core result on core_r. A pipe whose tail is blocked
    // freezes completely; bubbles are not collapsed.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        localparam int L = PIPE_LATENCY[p];

        logic [L-1:0]    vld;
        logic [ID_W-1:0] ids [L];

        assign adv_pipe[p]   = !vld[L-1] || (grant[p] && adv_out);
        assign tail_valid[p] = vld[L-1];
        assign tail_id[p]    = ids[L-1];
        assign core_res[p]   = core_r[p*DATA_W +: DATA_W];

        // Valid shift register of the pipe. Entry 0 captures the input-stage
        // op only when that op targets this pipe.
        always_ff @(posedge clk) begin
            if (rst || flush_now) begin
                vld <= '0;
            end else if (adv_pipe[p]) begin
                vld[0] <= valid_in && (sel_r == SEL_W'(p));
                for (int i = 1; i < L; i++) begin
                    vld[i] <= vld[i-1];
                end
            end
        end

        // Id shift register of the pipe. It carries data only and has no reset.
        always_ff @(posedge clk) begin
            if (adv_pipe[p]) begin
                ids[0] <= id_r;
                for (int i = 1; i < L; i++) begin
                    ids[i] <= ids[i-1];
                end
            end
        end
    end

    assign core_ce = adv_pipe;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // The search starts at pointer rr and takes the first pipe with a valid
    // tail. Each losing pipe keeps its tail, and the pipe stalls through
    // adv_pipe.
    // ------------------------------------------------------------------

    // Find the first valid tail at or after rr, wrapping around. Produce a
    // one-hot grant and the index of the winner.
    always_comb begin
        int idx;
        idx      = 0;
        any_tail = 1'b0;
        winner   = '0;
        grant    = '0;
        for (int k = 0; k < NUM_PIPES; k++) begin
            idx = (int'(rr) + k) % NUM_PIPES;
            if (!any_tail && tail_valid[idx]) begin
                any_tail   = 1'b1;
                winner     = SEL_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    // Move the pointer past the winner each time a tail is actually taken.
    // A flush leaves the pointer where it is.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (!flush_now && adv_out && any_tail) begin
            if (int'(winner) == NUM_PIPES - 1) begin
                rr <= '0;
            end else begin
                rr <= winner + SEL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Writeback register
    // The register reloads when it is empty or when its current result is
    // being accepted. It holds otherwise.
    // ------------------------------------------------------------------
    assign adv_out = !done_r || wb_ack;

    // Done flag of the writeback register.
    always_ff @(posedge clk) begin
        if (rst || flush_now) begin
            done_r <= 1'b0;
        end else if (adv_out) begin
            done_r <= any_tail;
        end
    end

    // Result and id of the writeback register, taken from the granted tail.
    always_ff @(posedge clk) begin
        if (adv_out) begin
            wb_rd <= core_res[winner];
            wb_id <= tail_id[winner];
        end
    end

    assign wb_done = done_r;

    // ------------------------------------------------------------------
    // A request must target an existing pipe. op_sel is widened first so the
    // check stays meaningful when NUM_PIPES is a power of two.
    // ------------------------------------------------------------------
    logic [31:0] op_sel_ext;
    assign op_sel_ext = 32'(op_sel);

    a_op_sel_legal: assert property (
        @(posedge clk) disable iff (rst)
        issue_new_request |-> (op_sel_ext < 32'(NUM_PIPES))
    );

endmodule

// File: tb/tb_fp_multi_pipe_unit.sv
// Testbench for fp_multi_pipe_unit.
// It models two cores (pipe0: a+b with latency 10, pipe1: a^b with latency 8).
// The driver pushes the expected {id, result} into one queue per pipe when a
// request is accepted. The monitor pops from those queues and compares
// whenever a writeback handshake occurs. Compile with +define+FP_PIPE_FLUSH_EN
// to include the flush scenario.
`timescale 1ns/1ps
module tb_fp_multi_pipe_unit;
    localparam int NUM_PIPES = 2;
    localparam int DATA_W    = 34;
    localparam int ID_W      = 8;
    localparam int SEL_W     = 1;
    localparam int L0        = 10;
    localparam int L1        = 8;
    localparam int EW        = ID_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [SEL_W-1:0]            op_sel = '0;
    logic [DATA_W-1:0]           rs1 = '0;
    logic [DATA_W-1:0]           rs2 = '0;
    logic                        issue_new_request = 1'b0;
    logic [ID_W-1:0]             issue_id = '0;
    logic                        issue_ready;
    logic [DATA_W-1:0]           core_a;
    logic [DATA_W-1:0]           core_b;
    logic [NUM_PIPES-1:0]        core_ce;
    logic [NUM_PIPES*DATA_W-1:0] core_r;
    logic                        wb_ack = 1'b0;
    logic                        wb_done;
    logic [ID_W-1:0]             wb_id;
    logic [DATA_W-1:0]           wb_rd;
`ifdef FP_PIPE_FLUSH_EN
    logic                        flush = 1'b0;
`endif

    fp_multi_pipe_unit #(
        .NUM_PIPES (NUM_PIPES),
        .DATA_W    (DATA_W),
        .ID_W      (ID_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef FP_PIPE_FLUSH_EN
        .flush             (flush),
`endif
        .op_sel            (op_sel),
        .rs1               (rs1),
        .rs2               (rs2),
        .issue_new_request (issue_new_request),
        .issue_id          (issue_id),
        .issue_ready       (issue_ready),
        .core_a            (core_a),
        .core_b            (core_b),
        .core_ce           (core_ce),
        .core_r            (core_r),
        .wb_ack            (wb_ack),
        .wb_done           (wb_done),
        .wb_id             (wb_id),
        .wb_rd             (wb_rd)
    );

    // ---------------- external core models ----------------
    logic [DATA_W-1:0] core0_q [L0];
    logic [DATA_W-1:0] core1_q [L1];

    always @(posedge clk) begin
        if (core_ce[0]) begin
            core0_q[0] <= core_a + core_b;
            for (int i = 1; i < L0; i++) core0_q[i] <= core0_q[i-1];
        end
        if (core_ce[1]) begin
            core1_q[0] <= core_a ^ core_b;
            for (int i = 1; i < L1; i++) core1_q[i] <= core1_q[i-1];
        end
    end
    assign core_r = {core1_q[L1-1], core0_q[L0-1]};

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [EW-1:0]   exp_q0 [$];
    logic [EW-1:0]   exp_q1 [$];
    logic [ID_W-1:0] ret_q [$];
    int              ret_cyc [$];
    logic [ID_W-1:0] next_id = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DATA_W-1:0] ref_result(input int sel, input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        if (sel == 0) r = a + b;
        else          r = a ^ b;
        return r;
    endfunction

    // ---------------- monitor ----------------
    logic              hold_valid = 1'b0;
    logic [ID_W-1:0]   hold_id;
    logic [DATA_W-1:0] hold_rd;
    logic [EW-1:0]     m_e;
    logic [EW-1:0]     m_head;
    logic              m_hit;

    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                chk("wb_hold_done", wb_done, 1);
                chk("wb_hold_id", wb_id, hold_id);
                chk("wb_hold_rd", wb_rd, hold_rd);
            end
            hold_valid = wb_done && !wb_ack;
            hold_id    = wb_id;
            hold_rd    = wb_rd;
            if (wb_done && wb_ack) begin
                ret_q.push_back(wb_id);
                ret_cyc.push_back(cyc);
                m_hit = 1'b0;
                m_e   = '0;
                if (exp_q0.size() > 0) begin
                    m_head = exp_q0[0];
                    if (m_head[EW-1:DATA_W] == wb_id) begin
                        m_e   = exp_q0.pop_front();
                        m_hit = 1'b1;
                    end
                end
                if (!m_hit && exp_q1.size() > 0) begin
                    m_head = exp_q1[0];
                    if (m_head[EW-1:DATA_W] == wb_id) begin
                        m_e   = exp_q1.pop_front();
                        m_hit = 1'b1;
                    end
                end
                chk("wb_id_expected", m_hit, 1);
                if (m_hit) chk("wb_rd", wb_rd, m_e[DATA_W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Every task is entered and left at posedge+1.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue_op(input int sel, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, output bit acc);
        op_sel            = SEL_W'(sel);
        rs1               = a;
        rs2               = b;
        issue_id          = next_id;
        issue_new_request = 1'b1;
        @(negedge clk);
        acc = issue_ready;
        if (acc) begin
            if (sel == 0) exp_q0.push_back({next_id, ref_result(sel, a, b)});
            else          exp_q1.push_back({next_id, ref_result(sel, a, b)});
            next_id++;
        end
        step();
        issue_new_request = 1'b0;
    endtask

    task automatic reset_dut(input int n);
        rst               = 1'b1;
        issue_new_request = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        wb_ack = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
            step();
        end
        repeat (4) step();
        chk("drain_empty", exp_q0.size() + exp_q1.size(), 0);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return DATA_W'({$urandom, $urandom});
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        bit              acc;
        int              n_acc;
        int              pos0;
        int              pos1;
        logic [ID_W-1:0] first0;
        logic [ID_W-1:0] ida;
        logic [ID_W-1:0] idb;

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_done", wb_done, 0);
        chk("reset_ready", issue_ready, 1);
        chk("reset_ce", core_ce, 2'b11);
        step();

        // Scenario 1: a single op to pipe0. wb_done must be high exactly
        // L0+2 cycles after acceptance, for one cycle only.
        wb_ack = 1'b1;
        ida = next_id;
        issue_op(0, rnd_data(), rnd_data(), acc);
        chk("t1_accept", acc, 1);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk("t1_done_timing", wb_done, (k == L0 + 2));
            if (k == L0 + 2) chk("t1_id", wb_id, ida);
        end
        step();

        // Scenario 2: ops alternate pipe0/pipe1, with ack tied high.
        // Op i done time = i + L + 2, so each pipe1 op (odd i, done at i+10)
        // overtakes the pipe0 op issued one cycle earlier (done at i-1+12).
        ret_q.delete();
        first0 = next_id;
        for (int i = 0; i < 20; i++) begin
            issue_op(i % 2, rnd_data(), rnd_data(), acc);
            chk("t2_ready", acc, 1);
        end
        drain(60);
        chk("t2_count", ret_q.size(), 20);
        if (ret_q.size() >= 20) begin
            for (int m = 0; m < 10; m++) begin
                chk("t2_order_odd", ret_q[2*m], ID_W'(first0 + 2*m + 1));
                chk("t2_order_even", ret_q[2*m+1], ID_W'(first0 + 2*m));
            end
        end
        pos0 = -1;
        pos1 = -1;
        foreach (ret_q[j]) begin
            if (ret_q[j] == first0)                    pos0 = j;
            if (ret_q[j] == ID_W'(first0 + 8'd1))      pos1 = j;
        end
        chk("t2_overtake", (pos1 >= 0) && (pos0 >= 0) && (pos1 < pos0), 1);

        // Scenario 3a: tails collide with rr=0. Pipe0 issued at t and pipe1
        // at t+2 both reach their tail in cycle t+11.
        reset_dut(2);
        wb_ack = 1'b1;
        ret_q.delete();
        ret_cyc.delete();
        ida = next_id;
        issue_op(0, rnd_data(), rnd_data(), acc);
        step();
        idb = next_id;
        issue_op(1, rnd_data(), rnd_data(), acc);
        drain(40);
        chk("t3a_count", ret_q.size(), 2);
        if (ret_q.size() >= 2) begin
            chk("t3a_first_pipe0", ret_q[0], ida);
            chk("t3a_second_pipe1", ret_q[1], idb);
            chk("t3a_back_to_back", ret_cyc[1] - ret_cyc[0], 1);
        end

        // Scenario 3b: a lone pipe0 retirement leaves rr=1, then the same
        // collision must favour pipe1.
        issue_op(0, rnd_data(), rnd_data(), acc);
        drain(40);
        ret_q.delete();
        ret_cyc.delete();
        ida = next_id;
        issue_op(0, rnd_data(), rnd_data(), acc);
        step();
        idb = next_id;
        issue_op(1, rnd_data(), rnd_data(), acc);
        drain(40);
        chk("t3b_count", ret_q.size(), 2);
        if (ret_q.size() >= 2) begin
            chk("t3b_first_pipe1", ret_q[0], idb);
            chk("t3b_second_pipe0", ret_q[1], ida);
            chk("t3b_back_to_back", ret_cyc[1] - ret_cyc[0], 1);
        end

        // Scenario 4: no ack while pipe1 is fed continuously. Capacity is
        // 8 (pipe) + 1 (input) + 1 (output) = 10 ops.
        wb_ack = 1'b0;
        n_acc  = 0;
        for (int i = 0; i < 30; i++) begin
            issue_op(1, rnd_data(), rnd_data(), acc);
            n_acc += int'(acc);
        end
        chk("t4_fill", n_acc, 10);
        chk("t4_ready_low", issue_ready, 0);
        chk("t4_done_held", wb_done, 1);
        drain(60);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 200; i++) begin
            wb_ack = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) step();
            else issue_op($urandom_range(0, 1), rnd_data(), rnd_data(), acc);
        end
        drain(200);

        // Scenario 5: reset with 5 ops in flight.
        wb_ack = 1'b1;
        for (int i = 0; i < 5; i++) issue_op($urandom_range(0, 1), rnd_data(), rnd_data(), acc);
        reset_dut(1);
        @(negedge clk);
        chk("t5_done_after_rst", wb_done, 0);
        chk("t5_ready_after_rst", issue_ready, 1);
        chk("t5_ce_after_rst", core_ce, 2'b11);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_no_stale", wb_done, 0);
        end
        step();

`ifdef FP_PIPE_FLUSH_EN
        // Scenario 6: flush with 4 ops in flight and a new request in the
        // same cycle. Only the request issued after the flush may retire.
        wb_ack = 1'b1;
        ret_q.delete();
        for (int i = 0; i < 4; i++) begin
            issue_op($urandom_range(0, 1), rnd_data(), rnd_data(), acc);
            chk("t6_accept", acc, 1);
        end
        flush             = 1'b1;
        op_sel            = 1'b1;
        rs1               = rnd_data();
        rs2               = rnd_data();
        issue_id          = next_id;
        issue_new_request = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        step();
        flush             = 1'b0;
        issue_new_request = 1'b0;
        next_id++;
        ida = next_id;
        issue_op(0, rnd_data(), rnd_data(), acc);
        chk("t6_ready_after_flush", acc, 1);
        drain(40);
        chk("t6_count", ret_q.size(), 1);
        if (ret_q.size() >= 1) chk("t6_survivor_id", ret_q[0], ida);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
